wire_alu_seq: RTL and testbench

- Parametrised successor to the wire-in adder/wire-out sample.
- Sequentially combines NCH operand words, e.g. from okWireIn endpoints, under a selectable op mode, with optional saturation, overflow reporting and a completion counter.
- Results and status drive okWireOut endpoints.
- Sits between endpoint wires and host-readable outputs in the ti_clk domain; started by a one-cycle pulse, e.g. from an okTriggerIn.

---
 rtl/wire_alu_seq.sv | 155 +++++++++++++++
 tb/tb_wire_alu_seq.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wire_alu_seq.sv
// Sequential multi-channel ALU between endpoint wires and host-readable outputs.
// It folds NCH snapshotted operands with SUM/SUB/MAX/MIN, one operand per clock.
module wire_alu_seq #(
   parameter int WIDTH = 16,
   parameter int NCH   = 4,
   parameter int CNTW  = 16
) (
   input  logic                 ti_clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [1:0]           op,
   input  logic                 sat_en,
   input  logic                 clr,
   input  logic [NCH*WIDTH-1:0] operands,
   output logic                 busy,
   output logic                 done,
   output logic [WIDTH-1:0]     result,
   output logic                 overflow,
   output logic                 ovf_sticky,
   output logic [CNTW-1:0]      ops_done
);

   localparam int ACCW = WIDTH + $clog2(NCH) + 1;
   localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;

   localparam logic [1:0] OP_SUM = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MAX = 2'b10;
   localparam logic [1:0] OP_MIN = 2'b11;

   localparam logic signed [ACCW-1:0] FULL = $signed({{(ACCW-WIDTH){1'b0}}, {WIDTH{1'b1}}});

   typedef enum logic {IDLE, RUN} state_t;

   function automatic logic signed [ACCW-1:0] widen(input logic [WIDTH-1:0] x);
      return $signed({{(ACCW-WIDTH){1'b0}}, x});
   endfunction

   function automatic logic signed [ACCW-1:0] step(input logic [1:0] mode,
                                                    input logic signed [ACCW-1:0] a,
                                                    input logic [WIDTH-1:0] x);
      logic signed [ACCW-1:0] xs;
      xs = widen(x);
      case (mode)
         OP_SUM:  step = a + xs;
         OP_SUB:  step = a - xs;
         OP_MAX:  step = (a > xs) ? a : xs;
         OP_MIN:  step = (a < xs) ? a : xs;
         default: step = a;
      endcase
   endfunction

   function automatic logic ovf_of(input logic [1:0] mode, input logic signed [ACCW-1:0] a);
      case (mode)
         OP_SUM:  ovf_of = (a > FULL);
         OP_SUB:  ovf_of = a[ACCW-1];
         default: ovf_of = 1'b0;
      endcase
   endfunction

   function automatic logic [WIDTH-1:0] saturate(input logic [1:0] mode, input logic sat,
                                                 input logic signed [ACCW-1:0] a);
      if (sat && ovf_of(mode, a))
         return (mode == OP_SUM) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
      return a[WIDTH-1:0];
   endfunction

   state_t                 state;
   logic [IDXW-1:0]        idx;
   logic [WIDTH-1:0]       snap [NCH];
   logic signed [ACCW-1:0] acc;
   logic [1:0]             op_q;
   logic                   sat_q;

   logic                   accept;
   logic                   last;
   logic                   finish;
   logic                   fin_ovf;
   logic                   fin_sat;
   logic [1:0]             fin_op;
   logic [WIDTH-1:0]       cur_x;
   logic signed [ACCW-1:0] acc0;
   logic signed [ACCW-1:0] acc_step;
   logic signed [ACCW-1:0] fin_acc;

   assign accept   = (state == IDLE) && start;
   assign acc0     = widen(operands[WIDTH-1:0]);
   assign cur_x    = snap[idx];
   assign acc_step = step(op_q, acc, cur_x);
   assign last     = (idx == IDXW'(NCH - 1));

   // A single-channel build finishes on the accepting edge, straight from the live inputs.
   assign finish  = (NCH == 1) ? accept : ((state == RUN) && last);
   assign fin_acc = (state == RUN) ? acc_step : acc0;
   assign fin_op  = (state == RUN) ? op_q : op;
   assign fin_sat = (state == RUN) ? sat_q : sat_en;
   assign fin_ovf = ovf_of(fin_op, fin_acc);

   always_ff @(posedge ti_clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         idx        <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         result     <= '0;
         overflow   <= 1'b0;
         ovf_sticky <= 1'b0;
         ops_done   <= '0;
      end else begin
         done <= 1'b0;
         if (clr) begin
            ops_done   <= '0;
            ovf_sticky <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (start) begin
                  idx <= IDXW'(1);
                  if (NCH > 1) begin
                     state <= RUN;
                     busy  <= 1'b1;
                  end
               end
            end
            RUN:     idx <= idx + IDXW'(1);
            default: state <= IDLE;
         endcase
         if (finish) begin
            state      <= IDLE;
            idx        <= '0;
            busy       <= 1'b0;
            done       <= 1'b1;
            result     <= saturate(fin_op, fin_sat, fin_acc);
            overflow   <= fin_ovf;
            ovf_sticky <= clr ? fin_ovf : (ovf_sticky | fin_ovf);
            if (!clr)
               ops_done <= ops_done + CNTW'(1);
         end
      end
   end

   // Datapath registers carry no reset; they are always loaded before use.
   always_ff @(posedge ti_clk) begin
      if (accept) begin
         for (int i = 0; i < NCH; i++)
            snap[i] <= operands[i*WIDTH +: WIDTH];
         op_q  <= op;
         sat_q <= sat_en;
         acc   <= acc0;
      end else if (state == RUN) begin
         acc <= acc_step;
      end
   end

endmodule

// File: tb/tb_wire_alu_seq.sv
// Bench for wire_alu_seq: a 4-channel instance and a 1-channel instance,
// directed scenarios plus randomized operations against an arithmetic model.
module tb_wire_alu_seq;
   localparam int W = 16;
   localparam int N = 4;
   localparam int C = 16;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [1:0]   op;
   logic         sat_en;
   logic         clr;
   logic [N*W-1:0] operands;
   logic         busy, done, overflow, ovf_sticky;
   logic [W-1:0] result;
   logic [C-1:0] ops_done;

   logic         start1;
   logic [W-1:0] operands1;
   logic         busy1, done1, overflow1, ovf_sticky1;
   logic [W-1:0] result1;
   logic [C-1:0] ops_done1;

   int   errors = 0;
   int   checks = 0;
   int   exp_cnt = 0;
   logic exp_sticky = 1'b0;
   logic busy1_seen = 1'b0;

   wire_alu_seq #(.WIDTH(W), .NCH(N), .CNTW(C)) dut (
      .ti_clk(clk), .rst_n(rst_n), .start(start), .op(op), .sat_en(sat_en), .clr(clr),
      .operands(operands), .busy(busy), .done(done), .result(result),
      .overflow(overflow), .ovf_sticky(ovf_sticky), .ops_done(ops_done)
   );

   wire_alu_seq #(.WIDTH(W), .NCH(1), .CNTW(C)) dut1 (
      .ti_clk(clk), .rst_n(rst_n), .start(start1), .op(op), .sat_en(sat_en), .clr(clr),
      .operands(operands1), .busy(busy1), .done(done1), .result(result1),
      .overflow(overflow1), .ovf_sticky(ovf_sticky1), .ops_done(ops_done1)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (busy1) busy1_seen <= 1'b1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

   // Reference: fold the operands with plain integer arithmetic.
   function automatic void model(input logic [1:0] m, input logic s, input logic [N*W-1:0] v,
                                 output logic [W-1:0] r, output logic o);
      longint a, x;
      a = longint'(v[W-1:0]);
      for (int i = 1; i < N; i++) begin
         x = longint'(v[i*W +: W]);
         case (m)
            2'd0: a = a + x;
            2'd1: a = a - x;
            2'd2: if (x > a) a = x;
            default: if (x < a) a = x;
         endcase
      end
      o = (m == 2'd0 && a > ((longint'(1) << W) - 1)) || (m == 2'd1 && a < 0);
      if (o && s) r = (m == 2'd0) ? {W{1'b1}} : {W{1'b0}};
      else        r = a[W-1:0];
   endfunction

   task automatic start_op(input logic [1:0] m, input logic s, input logic [N*W-1:0] v);
      @(negedge clk);
      op = m; sat_en = s; operands = v; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 1;
      while (!done && n < 20) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++; if ({busy, done, overflow, ovf_sticky} !== 4'b0) begin errors++;
         $display("FAIL reset_flags: got %b required 0000", {busy, done, overflow, ovf_sticky}); end
      checks++; if (result !== '0) begin errors++;
         $display("FAIL reset_result: got %h required 0000", result); end
      checks++; if (ops_done !== '0) begin errors++;
         $display("FAIL reset_ops_done: got %0d required 0", ops_done); end
      checks++; if ({busy1, done1, result1, ops_done1} !== '0) begin errors++;
         $display("FAIL reset_nch1: got busy=%b done=%b result=%h cnt=%0d required all 0",
                  busy1, done1, result1, ops_done1); end
      rst_n = 1'b1;
   endtask

   task automatic test_sum_basic();
      start_op(2'd0, 1'b0, {16'd4, 16'd3, 16'd2, 16'd1});
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_k: got %b required 1", busy); end
      @(negedge clk);
      checks++; if ({busy, done} !== 2'b10) begin errors++; $display("FAIL busy_k1: got %b required 10", {busy, done}); end
      @(negedge clk);
      checks++; if ({busy, done} !== 2'b10) begin errors++; $display("FAIL busy_k2: got %b required 10", {busy, done}); end
      @(negedge clk);
      checks++; if ({busy, done} !== 2'b01) begin errors++; $display("FAIL done_k3: got %b required 01", {busy, done}); end
      checks++; if (result !== 16'h000A) begin errors++; $display("FAIL sum_result: got %h required 000a", result); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL sum_ovf: got %b required 0", overflow); end
      exp_cnt = 1;
      checks++; if (ops_done !== C'(exp_cnt)) begin errors++; $display("FAIL sum_cnt: got %0d required %0d", ops_done, exp_cnt); end
      @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_width: got %b required 0", done); end
   endtask

   task automatic test_sum_overflow();
      int n;
      for (int s = 0; s < 2; s++) begin
         start_op(2'd0, s[0], {16'h0000, 16'h0002, 16'hFFFF, 16'hFFFF});
         wait_done(n);
         exp_cnt++;
         checks++; if (n !== N) begin errors++; $display("FAIL sumovf_latency: got %0d required %0d", n, N); end
         checks++; if (result !== (s ? 16'hFFFF : 16'h0000)) begin errors++;
            $display("FAIL sumovf_result sat=%0d: got %h required %h", s, result, s ? 16'hFFFF : 16'h0000); end
         checks++; if ({overflow, ovf_sticky} !== 2'b11) begin errors++;
            $display("FAIL sumovf_flags sat=%0d: got %b required 11", s, {overflow, ovf_sticky}); end
      end
      exp_sticky = 1'b1;
   endtask

   task automatic test_sub_clr();
      int n;
      for (int s = 0; s < 2; s++) begin
         start_op(2'd1, s[0], {16'd5, 16'd4, 16'd3, 16'd10});
         wait_done(n);
         exp_cnt++;
         checks++; if (result !== (s ? 16'h0000 : 16'hFFFE) || overflow !== 1'b1) begin errors++;
            $display("FAIL sub sat=%0d: got %h ovf=%b required %h ovf=1", s, result, overflow, s ? 16'h0000 : 16'hFFFE); end
      end
      checks++; if (ops_done !== C'(exp_cnt)) begin errors++; $display("FAIL sub_cnt: got %0d required %0d", ops_done, exp_cnt); end
      @(negedge clk); clr = 1'b1;
      @(negedge clk); clr = 1'b0;
      exp_cnt = 0; exp_sticky = 1'b0;
      checks++; if ({ovf_sticky, ops_done} !== '0) begin errors++;
         $display("FAIL clr: got sticky=%b cnt=%0d required 0 0", ovf_sticky, ops_done); end
   endtask

   task automatic test_max_min();
      int n;
      start_op(2'd2, 1'b1, {16'h7FFF, 16'h0003, 16'h8000, 16'h0007});
      wait_done(n); exp_cnt++;
      checks++; if (result !== 16'h8000 || overflow !== 1'b0) begin errors++;
         $display("FAIL max: got %h ovf=%b required 8000 ovf=0", result, overflow); end
      start_op(2'd3, 1'b1, {16'h7FFF, 16'h0003, 16'h8000, 16'h0007});
      wait_done(n); exp_cnt++;
      checks++; if (result !== 16'h0003 || overflow !== 1'b0) begin errors++;
         $display("FAIL min: got %h ovf=%b required 0003 ovf=0", result, overflow); end
      checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL maxmin_sticky: got %b required 0", ovf_sticky); end
   endtask

   task automatic test_back_to_back();
      int n;
      start_op(2'd0, 1'b0, {16'd1, 16'd1, 16'd1, 16'd1});
      start = 1'b1; operands = {4{16'h00FF}}; op = 2'd2;
      @(negedge clk);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      exp_cnt++;
      checks++; if (done !== 1'b1 || result !== 16'h0004) begin errors++;
         $display("FAIL ignore_start: got done=%b result=%h required done=1 result=0004", done, result); end
      checks++; if (ops_done !== C'(exp_cnt)) begin errors++; $display("FAIL ignore_cnt: got %0d required %0d", ops_done, exp_cnt); end
      // Request during the done cycle.
      op = 2'd0; operands = {4{16'd5}}; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++; if ({busy, done} !== 2'b10) begin errors++;
         $display("FAIL b2b_accept: got busy,done=%b required 10", {busy, done}); end
      wait_done(n); exp_cnt++;
      checks++; if (n !== N || result !== 16'h0014) begin errors++;
         $display("FAIL b2b_result: got n=%0d result=%h required n=%0d result=0014", n, result, N); end
   endtask

   task automatic test_clr_collision();
      start_op(2'd0, 1'b0, {16'h0000, 16'h0002, 16'hFFFF, 16'hFFFF});
      @(negedge clk);
      @(negedge clk); clr = 1'b1;
      @(negedge clk); clr = 1'b0;
      exp_cnt = 0; exp_sticky = 1'b1;
      checks++; if (done !== 1'b1 || ops_done !== '0 || ovf_sticky !== 1'b1) begin errors++;
         $display("FAIL clr_collide: got done=%b cnt=%0d sticky=%b required 1 0 1", done, ops_done, ovf_sticky); end
   endtask

   task automatic test_random();
      int n;
      logic [1:0] m;
      logic s, o;
      logic [N*W-1:0] v;
      logic [W-1:0] r;
      for (int it = 0; it < 40; it++) begin
         m = 2'($urandom_range(0, 3));
         s = 1'($urandom_range(0, 1));
         for (int c = 0; c < N; c++) begin
            case ($urandom_range(0, 3))
               0: v[c*W +: W] = W'($urandom);
               1: v[c*W +: W] = {W{1'b1}};
               2: v[c*W +: W] = '0;
               default: v[c*W +: W] = W'($urandom_range(0, 20));
            endcase
         end
         model(m, s, v, r, o);
         start_op(m, s, v);
         operands = {$urandom, $urandom};
         op = 2'($urandom_range(0, 3));
         sat_en = ~s;
         wait_done(n);
         exp_cnt++;
         exp_sticky = exp_sticky | o;
         checks++; if (n !== N) begin errors++; $display("FAIL rnd_latency #%0d: got %0d required %0d", it, n, N); end
         checks++; if (result !== r || overflow !== o) begin errors++;
            $display("FAIL rnd_result #%0d op=%0d sat=%0b ops=%h: got %h ovf=%b required %h ovf=%b",
                     it, m, s, v, result, overflow, r, o); end
         checks++; if (ovf_sticky !== exp_sticky || ops_done !== C'(exp_cnt)) begin errors++;
            $display("FAIL rnd_status #%0d: got sticky=%b cnt=%0d required sticky=%b cnt=%0d",
                     it, ovf_sticky, ops_done, exp_sticky, exp_cnt); end
         if ($urandom_range(0, 7) == 0) begin
            @(negedge clk); clr = 1'b1;
            @(negedge clk); clr = 1'b0;
            exp_cnt = 0; exp_sticky = 1'b0;
         end
      end
   endtask

   task automatic test_async_reset();
      int n;
      start_op(2'd0, 1'b0, {16'd9, 16'd9, 16'd9, 16'd9});
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++; if ({busy, done, overflow, ovf_sticky} !== 4'b0 || result !== '0 || ops_done !== '0) begin errors++;
         $display("FAIL async_reset: got busy=%b done=%b result=%h cnt=%0d required all 0",
                  busy, done, result, ops_done); end
      @(negedge clk);
      rst_n = 1'b1;
      exp_cnt = 0; exp_sticky = 1'b0;
      start_op(2'd0, 1'b0, {4{16'd5}});
      wait_done(n); exp_cnt++;
      checks++; if (result !== 16'h0014 || ops_done !== C'(exp_cnt)) begin errors++;
         $display("FAIL after_reset: got result=%h cnt=%0d required 0014 %0d", result, ops_done, exp_cnt); end
   endtask

   task automatic test_single_channel();
      @(negedge clk);
      op = 2'd0; sat_en = 1'b1; operands1 = 16'h1234; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      checks++; if (done1 !== 1'b1 || result1 !== 16'h1234 || overflow1 !== 1'b0 || ops_done1 !== C'(1)) begin errors++;
         $display("FAIL nch1_sum: got done=%b result=%h ovf=%b cnt=%0d required 1 1234 0 1",
                  done1, result1, overflow1, ops_done1); end
      op = 2'd1; operands1 = 16'hBEEF; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      checks++; if (done1 !== 1'b1 || result1 !== 16'hBEEF || overflow1 !== 1'b0 || ops_done1 !== C'(2)) begin errors++;
         $display("FAIL nch1_sub: got done=%b result=%h ovf=%b cnt=%0d required 1 beef 0 2",
                  done1, result1, overflow1, ops_done1); end
      @(negedge clk);
      checks++; if (done1 !== 1'b0 || busy1_seen !== 1'b0) begin errors++;
         $display("FAIL nch1_pulse: got done=%b busy_seen=%b required 0 0", done1, busy1_seen); end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; op = 2'd0; sat_en = 1'b0; clr = 1'b0; operands = '0;
      start1 = 1'b0; operands1 = '0;
      test_reset();
      test_sum_basic();
      test_sum_overflow();
      test_sub_clr();
      test_max_min();
      test_back_to_back();
      test_clr_collision();
      test_random();
      test_async_reset();
      test_single_channel();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
